branch_pc_sequencer: RTL

Program-counter sequencer for the 8-bit core: owns the PC register, resolves conditional branches from the EX stage and unconditional jumps from the ID stage, and redirects fetch. On every redirect it drives a multi-cycle flush of the IF/ID stages through a small state machine. It also keeps saturating branch-statistics counters. The fetch unit, hazard unit and the EX/ID stage decoders all connect to this block.

---
 rtl/branch_pc_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_pc_sequencer.sv
// Program-counter sequencer: resolves EX-stage branches and ID-stage jumps,
// redirects fetch, flushes IF/ID for a fixed number of cycles, and keeps branch statistics.
module branch_pc_sequencer #(
    parameter int              PC_W         = 8,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [2:0]       bCtrl,
    input  logic [7:0]       r1,
    input  logic [7:0]       r2,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [7:0]       br_off,
    input  logic             jmp_valid,
    input  logic [PC_W-1:0]  jmp_tgt,
    input  logic             cnt_clr,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             redirect,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t          state, state_nxt;
    logic [2:0]      fcnt, fcnt_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            redirect_nxt;

    logic [8:0]      diff;
    logic            eq, ltu, lt, cond;
    logic [PC_W-1:0] off_ext, br_tgt, jmp_addr;
    logic            sample, take_br, take_jmp, count_br;
    logic            jmp_lsb_unused;

    // Bit 8 of the widened subtract is the unsigned borrow.
    assign diff = {1'b0, r1} - {1'b0, r2};
    assign eq   = (diff[7:0] == 8'd0);
    assign ltu  = diff[8];
    assign lt   = (r1[7] != r2[7]) ? r1[7] : ltu;

    always_comb begin
        cond = 1'b0;
        case (bCtrl)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b010:  cond = lt;
            3'b011:  cond = ltu;
            3'b100:  cond = !lt;
            3'b101:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign off_ext        = PC_W'($signed(br_off));
    assign br_tgt         = br_pc + (off_ext << 1);
    assign jmp_addr       = {jmp_tgt[PC_W-1:1], 1'b0};
    assign jmp_lsb_unused = jmp_tgt[0];

    // A branch is older than a jump in the same cycle, so it wins.
    assign sample   = (state == RUN) && !stall;
    assign count_br = sample && br_valid;
    assign take_br  = count_br && cond;
    assign take_jmp = sample && jmp_valid && !take_br;

    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        pc_nxt       = pc;
        redirect_nxt = 1'b0;
        if (!stall) begin
            case (state)
                RUN: begin
                    if (take_br || take_jmp) begin
                        pc_nxt       = take_br ? br_tgt : jmp_addr;
                        redirect_nxt = 1'b1;
                        fcnt_nxt     = FLUSH_INIT;
                        state_nxt    = FLUSH;
                    end else begin
                        pc_nxt = pc + PC_W'(2);
                    end
                end
                FLUSH: begin
                    pc_nxt = pc + PC_W'(2);
                    if (fcnt == 3'd0) state_nxt = RUN;
                    else              fcnt_nxt  = fcnt - 3'd1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fcnt     <= 3'd0;
            pc       <= RESET_PC;
            flush    <= 1'b0;
            redirect <= 1'b0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            pc       <= pc_nxt;
            flush    <= (state_nxt == FLUSH);
            redirect <= redirect_nxt;
        end
    end

    // Clear beats increment and is honoured even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (count_br && (br_cnt != '1))   br_cnt    <= br_cnt + CNT_W'(1);
            if (take_br && (taken_cnt != '1)) taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule
